// File: rtl/fir_pkg.sv
// fir_pkg: shared definitions for the FIR tap reader.
//   - state encoding of the tap-walk FSM
//   - accumulator width helper
//   - reset/default coefficient value (boxcar)
//   - circular-pointer helpers for the sample history
package fir_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MAC  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam int COEF_DEFAULT = 1;

    // Sample is widened by one bit to become signed; M products need clog2(M) guard bits.
    function automatic int acc_width(input int dw, input int cw, input int m);
        return dw + 1 + cw + $clog2(m);
    endfunction

    // Advance a history pointer by one, wrapping M-1 back to 0.
    function automatic int unsigned ptr_inc(input int unsigned p, input int unsigned m);
        return (p >= m - 1) ? 0 : p + 1;
    endfunction

    // Step a history pointer back by d entries, modulo m (d < m).
    function automatic int unsigned ptr_back(input int unsigned p, input int unsigned d,
                                             input int unsigned m);
        return (p >= d) ? p - d : p + m - d;
    endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// fir_coef_bank: M x CW coefficient register file with a combinational read port.
// Configuration macro: FIR_COEF_WR_EN
//   defined   - writable registers, reset to 1 per tap.
//   undefined - no write/read ports, every tap reads constant 1.
// Ports:
//   clk, rst_n      clock / async active-low reset          (FIR_COEF_WR_EN only)
//   we, waddr, wdata write strobe, tap index, value          (FIR_COEF_WR_EN only)
//   raddr           tap index to read                        (FIR_COEF_WR_EN only)
//   rdata           signed coefficient for the addressed tap
module fir_coef_bank
    import fir_pkg::*;
#(
    parameter int M  = 6,
    parameter int CW = 12,
    localparam int PW = $clog2(M)
) (
`ifdef FIR_COEF_WR_EN
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [PW-1:0]        waddr,
    input  logic [CW-1:0]        wdata,
    input  logic [PW-1:0]        raddr,
`endif
    output logic signed [CW-1:0] rdata
);

`ifdef FIR_COEF_WR_EN
    logic [CW-1:0] coef_q [M];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < M; i++) coef_q[i] <= CW'(COEF_DEFAULT);
        end else if (we && (32'(waddr) < M)) begin
            coef_q[waddr] <= wdata;
        end
    end

    assign rdata = coef_q[raddr];
`else
    // Constant unity taps: the multiplier downstream folds into an adder.
    assign rdata = CW'(COEF_DEFAULT);
`endif

endmodule

// File: rtl/fir_tap_reader.sv
// fir_tap_reader: accepts one unsigned sample per handshake into an M-deep circular
// history, then multiply-accumulates all M taps (newest first) one per cycle and
// presents the signed result on a valid/ready output.
// Configuration macro: FIR_COEF_WR_EN (writable coefficients; otherwise boxcar sum).
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   in_valid, in_ready, x         sample input handshake
//   coef_we, coef_addr, coef_data coefficient write port (FIR_COEF_WR_EN only)
//   out_valid, out_ready, y       result output handshake
//
// state   | meaning
// IDLE    | in_ready=1, waiting for a sample (coefficient writes honoured here)
// MAC     | walking taps k=0..M-1, one product accumulated per cycle
// HOLD    | out_valid=1, y stable until out_ready
//
// Latency: sample presented in cycle 0 (accepted at its closing edge), out_valid
// is high M+1 cycles later; with out_ready high a new sample every M+2 cycles.
module fir_tap_reader
    import fir_pkg::*;
#(
    parameter int M  = 6,
    parameter int DW = 12,
    parameter int CW = 12,
    localparam int PW    = $clog2(M),
    localparam int ACC_W = acc_width(DW, CW, M)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DW-1:0]           x,
`ifdef FIR_COEF_WR_EN
    input  logic                    coef_we,
    input  logic [PW-1:0]           coef_addr,
    input  logic [CW-1:0]           coef_data,
`endif
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] y
);

    localparam int PRW = DW + 1 + CW;

    logic [1:0]              state_q, state_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           k_q, k_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] y_q, y_d;
    logic [DW-1:0]           hist_q [M];
    logic                    hist_we;

    logic [PW-1:0]           rd_idx;
    logic signed [CW-1:0]    coef_k;
    logic signed [PRW-1:0]   sample_w, coef_w, prod;

    // wr_ptr already points past the newest sample, so tap k sits k+1 entries back.
    assign rd_idx = PW'(ptr_back(ptr_back(32'(wr_ptr_q), 1, M), 32'(k_q), M));

    fir_coef_bank #(.M(M), .CW(CW)) u_coef (
`ifdef FIR_COEF_WR_EN
        .clk   (clk),
        .rst_n (rst_n),
        .we    (coef_we && (state_q == ST_IDLE)),
        .waddr (coef_addr),
        .wdata (coef_data),
        .raddr (k_q),
`endif
        .rdata (coef_k)
    );

    assign sample_w = PRW'({1'b0, hist_q[rd_idx]});
    assign coef_w   = PRW'(coef_k);
    assign prod     = sample_w * coef_w;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        k_d      = k_q;
        acc_d    = acc_q;
        y_d      = y_q;
        hist_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    hist_we  = 1'b1;
                    wr_ptr_d = PW'(ptr_inc(32'(wr_ptr_q), M));
                    acc_d    = '0;
                    k_d      = '0;
                    state_d  = ST_MAC;
                end
            end
            ST_MAC: begin
                acc_d = acc_q + ACC_W'(prod);
                if (k_q == PW'(M - 1)) begin
                    y_d     = acc_d;
                    k_d     = '0;
                    state_d = ST_HOLD;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            k_q      <= '0;
            acc_q    <= '0;
            y_q      <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            k_q      <= k_d;
            acc_q    <= acc_d;
            y_q      <= y_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < M; i++) hist_q[i] <= '0;
        end else if (hist_we) begin
            hist_q[wr_ptr_q] <= x;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_HOLD);
    assign y         = y_q;

endmodule

// File: tb/tb_fir_tap_reader.sv
module tb_fir_tap_reader;

    localparam int M     = 6;
    localparam int DW    = 12;
    localparam int CW    = 12;
    localparam int PW    = $clog2(M);
    localparam int ACC_W = DW + 1 + CW + PW;

    logic                    clk       = 1'b0;
    logic                    rst_n     = 1'b0;
    logic                    in_valid  = 1'b0;
    logic                    out_ready = 1'b1;
    logic [DW-1:0]           x         = '0;
    logic                    in_ready;
    logic                    out_valid;
    logic signed [ACC_W-1:0] y;
`ifdef FIR_COEF_WR_EN
    logic                    coef_we   = 1'b0;
    logic [PW-1:0]           coef_addr = '0;
    logic [CW-1:0]           coef_data = '0;
`endif

    always #5 clk = ~clk;

    fir_tap_reader #(.M(M), .DW(DW), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
`ifdef FIR_COEF_WR_EN
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y)
    );

    int     n_checks = 0;
    int     n_pass   = 0;
    int     lat      = 0;
    longint model_hist[$];
    longint model_coef[M];
    longint exp_y    = 0;
    bit     pending  = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Filter output from the definition: sum of coef[k] * (k-th newest sample).
    function automatic longint model_sum();
        longint s = 0;
        for (int k = 0; k < M; k++)
            s += model_coef[k] * model_hist[model_hist.size() - 1 - k];
        return s;
    endfunction

    task automatic model_reset();
        model_hist.delete();
        for (int i = 0; i < M; i++) model_hist.push_back(0);
        for (int i = 0; i < M; i++) model_coef[i] = 1;
        pending = 1'b0;
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        chk("ready_valid_exclusive", longint'(in_ready & out_valid), 0);
        chk("spurious_out_valid", longint'(out_valid & ~pending), 0);
        if (out_valid) chk("y_vs_model", longint'(y), exp_y);
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("reset_in_ready", longint'(in_ready), 1);
        chk("reset_out_valid", longint'(out_valid), 0);
        chk("reset_y", longint'(y), 0);
    endtask

    task automatic start_sample(input longint v);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) chk("in_ready_timeout", 0, 1);
        x        = DW'(v);
        in_valid = 1'b1;
        model_hist.push_back(v);
        exp_y   = model_sum();
        pending = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = 1;
    endtask

    // Counts edges from the accepting edge (inclusive) to out_valid.
    task automatic wait_result();
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency_edges", lat, M + 1);
    endtask

    task automatic finish_handshake();
        @(posedge clk);
        #1;
        pending = 1'b0;
    endtask

    task automatic send(input longint v);
        start_sample(v);
        wait_result();
        finish_handshake();
    endtask

`ifdef FIR_COEF_WR_EN
    task automatic write_coef_idle(input int a, input longint d);
        @(negedge clk);
        chk("coef_write_in_idle", longint'(in_ready), 1);
        coef_we   = 1'b1;
        coef_addr = PW'(a);
        coef_data = CW'(d);
        @(posedge clk);
        #1;
        coef_we = 1'b0;
        model_coef[a] = d;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1);
    end

    initial begin
        model_reset();
        do_reset();

        // Single sample against empty history.
        send(10);
        chk("single_x10_y", longint'(y), 10);
        chk("y_held_after_handshake_out_valid", longint'(out_valid), 0);

        // Fill history, then wrap the write pointer.
        do_reset();
        for (int i = 1; i <= 6; i++) send(i);
        chk("sixth_result_y", longint'(y), 21);
        send(100);
        chk("wrap_result_y", longint'(y), 120);

        // Back-pressure: HOLD for 5 cycles with an in_valid pulse that must be ignored.
        out_ready = 1'b0;
        start_sample(40);
        wait_result();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            x        = DW'(999);
            chk("hold_in_ready", longint'(in_ready), 0);
            chk("hold_out_valid", longint'(out_valid), 1);
            chk("hold_y_literal", longint'(y), 158);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        finish_handshake();
        chk("hold_released_out_valid", longint'(out_valid), 0);
        send(1);
        chk("after_hold_y", longint'(y), 156);

        // Reset in the middle of a MAC pass.
        start_sample(50);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midmac_reset_out_valid", longint'(out_valid), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("midmac_release_in_ready", longint'(in_ready), 1);
        repeat (M + 3) @(negedge clk);
        send(7);
        chk("after_midmac_reset_y", longint'(y), 7);

`ifdef FIR_COEF_WR_EN
        // Programmed coefficients, and a write during MAC that must be ignored.
        do_reset();
        write_coef_idle(0, -1);
        for (int a = 1; a < M; a++) write_coef_idle(a, 0);
        send(100);
        chk("coef_neg1_y", longint'(y), -100);
        start_sample(50);
        coef_we   = 1'b1;
        coef_addr = '0;
        coef_data = CW'(5);
        @(posedge clk);
        #1;
        coef_we = 1'b0;
        lat++;
        wait_result();
        finish_handshake();
        chk("coef_write_in_mac_ignored_y", longint'(y), -50);

        // Extreme magnitudes on every tap.
        do_reset();
        for (int a = 0; a < M; a++) write_coef_idle(a, -2048);
        for (int i = 0; i < M; i++) send(4095);
        chk("stress_y", longint'(y), -50319360);
`else
        // Full-scale moving sum.
        do_reset();
        for (int i = 0; i < M; i++) send(4095);
        chk("stress_boxcar_y", longint'(y), 24570);
`endif

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
